// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: programmable serial pattern matcher with fill qualification, overlap control and saturating match count
module seq_pattern_detector #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_0101),
  parameter int                 DEF_LEN = 3,
  parameter bit                 DEF_OVL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               a,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   cur_len
);
  logic [MAX_LEN-2:0] history;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   len_c;
  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic               ovl;
  logic               hit;
  // Compare only the low cur_len bits of {history, a}; a config write swallows the sample
  always_comb begin
    win = {history, a};
    for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(cur_len);
    len_c = cfg_len == '0 ? LEN_W'(1) : cfg_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;
    hit = !cfg_we && in_valid && fill >= cur_len - LEN_W'(1) && ((win ^ pat) & mask) == '0;
  end
  // Configuration and sample history; non-overlap hits restart the fill so the next match needs fresh bits
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      history <= '0;
      fill    <= '0;
      pat     <= DEF_PAT;
      cur_len <= LEN_W'(DEF_LEN);
      ovl     <= DEF_OVL;
    end else if (cfg_we) begin
      history <= '0;
      fill    <= '0;
      pat     <= cfg_pat;
      cur_len <= len_c;
      ovl     <= cfg_ovl;
    end else if (in_valid) begin
      history <= win[MAX_LEN-2:0];
      fill    <= hit && !ovl ? '0 : fill == LEN_W'(MAX_LEN - 1) ? fill : fill + LEN_W'(1);
    end
  // Registered match pulse and saturating match counter, clear wins over a hit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match     <= hit;
      match_cnt <= cnt_clr ? '0 : hit && match_cnt != '1 ? match_cnt + CNT_W'(1) : match_cnt;
    end
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed table-driven bench for seq_pattern_detector
module tb_seq_pattern_detector;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       a = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_ovl = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       match, match2;
  logic [7:0] match_cnt;
  logic [1:0] cnt2;
  logic [3:0] cur_len, len2;
  int         checks = 0;
  int         errors = 0;

  seq_pattern_detector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr), .match(match),
    .match_cnt(match_cnt), .cur_len(cur_len)
  );

  seq_pattern_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr), .match(match2),
    .match_cnt(cnt2), .cur_len(len2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, we;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl, clr, v, a, em;
    logic [7:0] ec;
    logic [3:0] el;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t r(logic rs, logic we, logic [7:0] pat, logic [3:0] len, logic ovl,
                             logic clr, logic v, logic b, logic em, logic [7:0] ec, logic [3:0] el);
    vec_t x;
    x.rst = rs; x.we = we; x.pat = pat; x.len = len; x.ovl = ovl; x.clr = clr;
    x.v = v; x.a = b; x.em = em; x.ec = ec; x.el = el;
    return x;
  endfunction

  function automatic vec_t bit_in(logic b, logic em, logic [7:0] ec, logic [3:0] el);
    return r(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, b, em, ec, el);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rs, logic we, logic [7:0] pat, logic [3:0] len, logic ovl,
                       logic clr, logic v, logic b);
    rst = rs; cfg_we = we; cfg_pat = pat; cfg_len = len; cfg_ovl = ovl;
    cnt_clr = clr; in_valid = v; a = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] a5;
    logic [10:0] alt;
    a5 = 8'hA5;
    alt = 11'b101_0101_0101;
    // reset, default pattern 101 overlapping
    tv.push_back(r(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 3));
    tv.push_back(bit_in(1, 0, 0, 3));
    tv.push_back(bit_in(0, 0, 0, 3));
    tv.push_back(bit_in(1, 1, 1, 3));
    tv.push_back(bit_in(0, 0, 1, 3));
    tv.push_back(bit_in(1, 1, 2, 3));
    tv.push_back(r(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2, 3));
    // fill qualification after reset
    tv.push_back(r(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 3));
    tv.push_back(bit_in(0, 0, 0, 3));
    tv.push_back(bit_in(1, 0, 0, 3));
    tv.push_back(r(0, 1, 8'h01, 4'd3, 1, 0, 0, 0, 0, 0, 3));
    tv.push_back(bit_in(1, 0, 0, 3));
    tv.push_back(bit_in(0, 0, 0, 3));
    tv.push_back(bit_in(0, 0, 0, 3));
    tv.push_back(bit_in(1, 1, 1, 3));
    // 1111 non-overlapping then overlapping
    tv.push_back(r(0, 1, 8'h0F, 4'd4, 0, 1, 0, 0, 0, 0, 4));
    for (int i = 1; i <= 8; i++)
      tv.push_back(bit_in(1, i == 4 || i == 8, i < 4 ? 0 : i < 8 ? 1 : 2, 4));
    tv.push_back(r(0, 1, 8'h0F, 4'd4, 1, 1, 0, 0, 0, 0, 4));
    for (int i = 1; i <= 8; i++)
      tv.push_back(bit_in(1, i >= 4, i < 4 ? 0 : 8'(i - 3), 4));
    // invalid gaps hold history
    tv.push_back(r(0, 1, 8'h05, 4'd3, 1, 1, 0, 0, 0, 0, 3));
    tv.push_back(bit_in(1, 0, 0, 3));
    for (int i = 0; i < 3; i++) tv.push_back(r(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 3));
    tv.push_back(bit_in(0, 0, 0, 3));
    tv.push_back(bit_in(1, 1, 1, 3));
    // length clamp low, high bits of pattern ignored, count untouched by config
    tv.push_back(r(0, 1, 8'hFF, 4'd0, 1, 0, 0, 0, 0, 1, 1));
    tv.push_back(bit_in(1, 1, 2, 1));
    tv.push_back(bit_in(0, 0, 2, 1));
    // length clamp high, full 8-bit pattern
    tv.push_back(r(0, 1, 8'hA5, 4'd15, 1, 0, 0, 0, 0, 2, 8));
    for (int i = 7; i >= 0; i--) tv.push_back(bit_in(a5[i], i == 0, i == 0 ? 3 : 2, 8));
    // config write on the completing bit discards it and clears history
    tv.push_back(r(0, 1, 8'h05, 4'd3, 1, 0, 0, 0, 0, 3, 3));
    tv.push_back(bit_in(1, 0, 3, 3));
    tv.push_back(bit_in(0, 0, 3, 3));
    tv.push_back(r(0, 1, 8'h05, 4'd3, 1, 0, 1, 1, 0, 3, 3));
    tv.push_back(bit_in(0, 0, 3, 3));
    tv.push_back(bit_in(1, 0, 3, 3));
    tv.push_back(bit_in(0, 0, 3, 3));
    tv.push_back(bit_in(1, 1, 4, 3));
    // reset between bits 2 and 3
    tv.push_back(bit_in(1, 0, 4, 3));
    tv.push_back(bit_in(0, 0, 4, 3));
    tv.push_back(r(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 3));
    tv.push_back(bit_in(1, 0, 0, 3));

    repeat (2) @(posedge clk);
    #1;
    chk("reset match", 32'(match), 0);
    chk("reset cnt", 32'(match_cnt), 0);
    chk("reset len", 32'(cur_len), 3);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].we, tv[i].pat, tv[i].len, tv[i].ovl, tv[i].clr, tv[i].v, tv[i].a);
      chk($sformatf("row%0d match", i), 32'(match), 32'(tv[i].em));
      chk($sformatf("row%0d cnt", i), 32'(match_cnt), 32'(tv[i].ec));
      chk($sformatf("row%0d len", i), 32'(cur_len), 32'(tv[i].el));
    end

    // 2-bit counter saturates after five overlapping 101 matches
    drive(1, 0, 8'h00, 4'd0, 0, 0, 0, 0);
    for (int i = 10; i >= 0; i--) drive(0, 0, 8'h00, 4'd0, 0, 0, 1, alt[i]);
    chk("sat match", 32'(match2), 1);
    chk("sat cnt", 32'(cnt2), 3);
    drive(0, 0, 8'h00, 4'd0, 0, 0, 0, 0);
    chk("sat hold", 32'(cnt2), 3);
    drive(0, 0, 8'h00, 4'd0, 0, 0, 1, 0);
    drive(0, 0, 8'h00, 4'd0, 0, 1, 1, 1);
    chk("clr hit match", 32'(match2), 1);
    chk("clr hit cnt", 32'(cnt2), 0);
    chk("clr hit cnt8", 32'(match_cnt), 0);

    // async reset drops a pending match pulse immediately
    drive(1, 0, 8'h00, 4'd0, 0, 0, 0, 0);
    drive(0, 0, 8'h00, 4'd0, 0, 0, 1, 1);
    drive(0, 0, 8'h00, 4'd0, 0, 0, 1, 0);
    drive(0, 0, 8'h00, 4'd0, 0, 0, 1, 1);
    chk("pre-rst match", 32'(match), 1);
    rst = 1'b1;
    #1;
    chk("async rst match", 32'(match), 0);
    chk("async rst cnt", 32'(match_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst match", 32'(match), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
